// File: rtl/iob_axi_burst_planner.sv
// -----------------------------------------------------------------------------
// iob_axi_burst_planner
//
// Splits one transfer command (start byte address, word count, direction) into
// a sequence of AXI-legal burst descriptors. A burst never exceeds
// 2^AXI_LEN_W beats and never crosses a 2^BOUNDARY_W-byte boundary. At most
// MAX_OUTST bursts may be issued and not yet completed at any time.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   cke_i            clock enable; 0 freezes all registers and blocks handshakes
//   cmd_*            command channel (valid/ready, addr, len in words, dir)
//   burst_*_o        burst descriptor channel (valid, addr, len = beats-1,
//                    dir, last), burst_ready_i from the AXI engine
//   burst_done_i     one-cycle pulse per completed burst
//   burst_error_i    completion error, sampled with burst_done_i
//   busy_o           command in progress
//   done_o           one-cycle pulse in the first idle cycle after a command
//   error_o          sticky error for the current/last command
// -----------------------------------------------------------------------------
module iob_axi_burst_planner #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int AXI_LEN_W  = 8,
  parameter int BOUNDARY_W = 12,
  parameter int MAX_OUTST  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cke_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [ADDR_W-1:0]    cmd_addr_i,
  input  logic [LEN_W-1:0]     cmd_len_i,
  input  logic                 cmd_dir_i,
  output logic                 burst_valid_o,
  input  logic                 burst_ready_i,
  output logic [ADDR_W-1:0]    burst_addr_o,
  output logic [AXI_LEN_W-1:0] burst_len_o,
  output logic                 burst_dir_o,
  output logic                 burst_last_o,
  input  logic                 burst_done_i,
  input  logic                 burst_error_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  localparam int OFF  = $clog2(DATA_W / 8);
  localparam int WA_W = ADDR_W - OFF;      // word address width
  localparam int BW   = BOUNDARY_W - OFF;  // boundary size in word-address bits
  localparam int CW0  = (LEN_W > AXI_LEN_W) ? LEN_W : AXI_LEN_W;
  localparam int CW   = ((CW0 > BW) ? CW0 : BW) + 1;  // sizing arithmetic width
  localparam int OW   = $clog2(MAX_OUTST + 1);

  localparam logic [CW-1:0] MAX_BEATS = CW'(1) << AXI_LEN_W;
  localparam logic [CW-1:0] BND_WORDS = CW'(1) << BW;
  localparam logic [OW-1:0] OUTST_LIM = OW'(MAX_OUTST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WA_W-1:0] waddr_q, waddr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic            dir_q, dir_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  // ---------------------------------------------------------------------------
  // Burst sizing: smallest of remaining words, AXI max burst, and words left
  // before the next boundary.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] rem_ext;
  logic [CW-1:0] to_bnd;
  logic [CW-1:0] beats_a;
  logic [CW-1:0] beats;

  assign rem_ext = CW'(rem_q);
  assign to_bnd  = BND_WORDS - CW'(waddr_q[BW-1:0]);
  assign beats_a = (rem_ext < MAX_BEATS) ? rem_ext : MAX_BEATS;
  assign beats   = (beats_a < to_bnd) ? beats_a : to_bnd;

  logic issue_ok;
  logic hs;
  logic done_dec;

  assign issue_ok = (state_q == ISSUE) && cke_i && (outst_q < OUTST_LIM);
  assign hs       = issue_ok && burst_ready_i;
  // Completions with nothing outstanding are stale (e.g. after a reset) and dropped.
  assign done_dec = burst_done_i && (outst_q != '0);

  // Length and last are gated to the ISSUE state so that idle outputs read 0
  // instead of the (beats-1) underflow produced by rem = 0.
  assign burst_valid_o = issue_ok;
  assign burst_addr_o  = ADDR_W'(waddr_q) << OFF;
  assign burst_len_o   = (state_q == ISSUE) ? AXI_LEN_W'(beats - CW'(1)) : '0;
  assign burst_last_o  = (state_q == ISSUE) && (beats == rem_ext);
  assign burst_dir_o   = dir_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign error_o       = err_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    waddr_d     = waddr_q;
    rem_d       = rem_q;
    dir_d       = dir_q;
    err_d       = err_q;
    done_d      = 1'b0;
    outst_d     = outst_q;
    cmd_ready_o = 1'b0;

    // Issue and completion in the same cycle cancel out.
    case ({hs, done_dec})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    if (done_dec && burst_error_i) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cmd_ready_o = cke_i;
        if (cmd_valid_i && cke_i) begin
          err_d = 1'b0;
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            waddr_d = WA_W'(cmd_addr_i >> OFF);
            rem_d   = cmd_len_i;
            dir_d   = cmd_dir_i;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (hs) begin
          waddr_d = waddr_q + WA_W'(beats);
          rem_d   = rem_q - LEN_W'(beats);
          if (rem_d == '0) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (outst_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      waddr_q <= '0;
      rem_q   <= '0;
      outst_q <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      rem_q   <= rem_d;
      outst_q <= outst_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule
